// File: rtl/gray_pkg.sv
// Shared mode encoding and width-parameterised gray/binary conversion helpers.
// Helpers operate on a 32-bit container; bits at and above w are treated as zero.
package gray_pkg;

  typedef enum logic {
    MODE_G2B = 1'b0,
    MODE_B2G = 1'b1
  } mode_e;

  localparam int unsigned MAX_WIDTH = 32;

  function automatic logic [MAX_WIDTH-1:0] width_mask(input int unsigned w);
    return (w >= MAX_WIDTH) ? '1 : ((32'd1 << w) - 32'd1);
  endfunction

  function automatic logic [MAX_WIDTH-1:0] bin2gray(input logic [MAX_WIDTH-1:0] b,
                                                    input int unsigned w);
    logic [MAX_WIDTH-1:0] bm;
    bm = b & width_mask(w);
    return bm ^ (bm >> 1);
  endfunction

  function automatic logic [MAX_WIDTH-1:0] gray2bin(input logic [MAX_WIDTH-1:0] g,
                                                    input int unsigned w);
    logic [MAX_WIDTH-1:0] gm;
    logic [MAX_WIDTH-1:0] b;
    gm = g & width_mask(w);
    b  = '0;
    // Each binary bit is the parity of the gray bits at and above it.
    for (int unsigned i = 0; i < MAX_WIDTH; i++) begin
      b[i] = ^(gm >> i);
    end
    return b;
  endfunction

endpackage

// File: rtl/gray_popcnt_le1.sv
// Flags a difference word with more than one bit set (gray adjacency violation).
module gray_popcnt_le1 #(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] diff,
  output logic             multi_bit
);

  // Clearing the lowest set bit leaves a nonzero word only if two or more were set.
  assign multi_bit = |(diff & (diff - WIDTH'(1)));

endmodule

// File: rtl/gray_conv_pipe.sv
// Gray<->binary converter with a one-entry valid/ready output register.
// Define GRAY_CONV_ADJCHK_EN to compile in the gray adjacency checker.
module gray_conv_pipe
  import gray_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_mode,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_mode,
  output logic             adj_err,
  output logic             adj_err_sticky
);

  mode_e            in_mode_e;
  logic             accept;
  logic [WIDTH-1:0] conv;

  assign in_mode_e = mode_e'(in_mode);
  assign in_ready  = !out_valid || out_ready;
  assign accept    = in_valid && in_ready;

  assign conv = (in_mode_e == MODE_B2G) ? WIDTH'(bin2gray(32'(in_data), WIDTH))
                                        : WIDTH'(gray2bin(32'(in_data), WIDTH));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_mode  <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_data  <= conv;
      out_mode  <= in_mode;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef GRAY_CONV_ADJCHK_EN
  logic             hist_valid;
  mode_e            hist_mode;
  logic [WIDTH-1:0] hist_gray;
  logic [WIDTH-1:0] gray_word;
  logic             multi_bit;
  logic             adj_hit;

  // The gray side of the transaction is the input in G2B mode, the result in B2G mode.
  assign gray_word = (in_mode_e == MODE_G2B) ? in_data : conv;
  assign adj_hit   = hist_valid && (hist_mode == in_mode_e) && multi_bit;

  gray_popcnt_le1 #(.WIDTH(WIDTH)) u_popcnt (
    .diff      (gray_word ^ hist_gray),
    .multi_bit (multi_bit)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist_valid     <= 1'b0;
      hist_mode      <= MODE_G2B;
      hist_gray      <= '0;
      adj_err        <= 1'b0;
      adj_err_sticky <= 1'b0;
    end else if (accept) begin
      hist_valid     <= 1'b1;
      hist_mode      <= in_mode_e;
      hist_gray      <= gray_word;
      adj_err        <= adj_hit;
      adj_err_sticky <= adj_err_sticky | adj_hit;
    end
  end
`else
  assign adj_err        = 1'b0;
  assign adj_err_sticky = 1'b0;
`endif

endmodule
